// File: rtl/alu_cmd_issuer_if.sv
// Handshake bundle for the ALU command-issue stage.
//   Command side : cmd_valid/cmd_ready handshake carrying cmd_a, cmd_b, cmd_fun,
//                  plus flush to discard everything buffered or pending.
//   Issue side   : issue_valid/alu_ready handshake carrying alu_a, alu_b,
//                  alu_fun and unit_sel toward the ALU unit decoder.
//   Status       : fifo_level (buffered entries, output stage excluded) and
//                  issue_count (wrapping count of completed issues).
// The slave modport is the issuer itself; master is whoever drives commands
// and plays the ALU (the testbench here).
interface alu_cmd_issuer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0] cmd_b;
  logic [3:0]            cmd_fun;
  logic                  flush;
  logic                  issue_valid;
  logic                  alu_ready;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [3:0]            alu_fun;
  logic [1:0]            unit_sel;
  logic [LW-1:0]         fifo_level;
  logic [7:0]            issue_count;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_fun, flush, alu_ready,
    input  cmd_ready, issue_valid, alu_a, alu_b, alu_fun, unit_sel,
           fifo_level, issue_count
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_fun, flush, alu_ready,
    output cmd_ready, issue_valid, alu_a, alu_b, alu_fun, unit_sel,
           fifo_level, issue_count
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// ALU command-issue stage. Commands accepted on the cmd handshake are queued
// in a small circular FIFO and handed one per cycle to a registered output
// stage that presents them to the ALU until alu_ready takes them.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - alu_cmd_issuer_if.slave (command input, issue output, status)
module alu_cmd_issuer #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_cmd_issuer_if.slave    bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 2 * DATA_WIDTH + 4;

  typedef enum logic {
    EMPTY,
    LOADED
  } state_t;

  state_t                state;
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [EW-1:0]         head;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic                  full;
  logic                  nonempty;
  logic                  push;
  logic                  pop;
  logic                  transfer;
  logic                  issue_valid_q;
  logic [DATA_WIDTH-1:0] alu_a_q;
  logic [DATA_WIDTH-1:0] alu_b_q;
  logic [3:0]            alu_fun_q;
  logic [7:0]            issue_count_q;

  // Ready looks only at registered occupancy and flush, so a pop in the same
  // cycle never frees a slot early and alu_ready has no path to cmd_ready.
  assign full          = (level == LW'(FIFO_DEPTH));
  assign nonempty      = (level != '0);
  assign bus.cmd_ready = ~full & ~bus.flush;
  assign push          = bus.cmd_valid & bus.cmd_ready;
  assign transfer      = (state == LOADED) & bus.alu_ready & ~bus.flush;
  // The output stage reloads when it is empty or its command is being taken.
  assign pop           = ~bus.flush & nonempty &
                         ((state == EMPTY) | bus.alu_ready);
  assign head          = mem[rd_ptr];

  assign bus.issue_valid = issue_valid_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_fun     = alu_fun_q;
  assign bus.unit_sel    = alu_fun_q[3:2];
  assign bus.fifo_level  = level;
  assign bus.issue_count = issue_count_q;

  // Storage array: no reset needed, occupancy is tracked by level/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.cmd_a, bus.cmd_b, bus.cmd_fun};
    end
  end

  // Pointers, occupancy, output-stage FSM and issue counter. Flush wins over
  // everything else but leaves the last presented command and the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= EMPTY;
      issue_valid_q <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_fun_q     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      issue_count_q <= '0;
    end else if (bus.flush) begin
      state         <= EMPTY;
      issue_valid_q <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr                         <= rd_ptr + PW'(1);
        {alu_a_q, alu_b_q, alu_fun_q}  <= head;
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
      if (transfer) begin
        issue_count_q <= issue_count_q + 8'd1;
      end
      case (state)
        EMPTY: begin
          if (nonempty) begin
            state         <= LOADED;
            issue_valid_q <= 1'b1;
          end
        end
        LOADED: begin
          if (bus.alu_ready && !nonempty) begin
            state         <= EMPTY;
            issue_valid_q <= 1'b0;
          end
        end
        default: begin
          state         <= EMPTY;
          issue_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer. A queue-based reference model
// tracks buffered commands, the presented command and the issue count, and
// every cycle the DUT outputs are compared against it.
module tb_alu_cmd_issuer;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    f;
  } cmd_t;

  logic clk;
  logic rst;

  alu_cmd_issuer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) ifc ();

  alu_cmd_issuer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  cmd_t       mq[$];
  bit         m_valid;
  cmd_t       m_cmd;
  logic [7:0] m_count;
  int         m_total;

  // Single comparison point: counts the check and reports on mismatch.
  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_valid = 1'b0;
    m_cmd   = '0;
    m_count = 8'd0;
    m_total = 0;
  endtask

  // Reset values hold for every output.
  task automatic checkReset(input string tag);
    chk({tag, "_valid"}, 32'(ifc.issue_valid), 32'd0);
    chk({tag, "_level"}, 32'(ifc.fifo_level), 32'd0);
    chk({tag, "_ready"}, 32'(ifc.cmd_ready), 32'd1);
    chk({tag, "_count"}, 32'(ifc.issue_count), 32'd0);
    chk({tag, "_a"}, 32'(ifc.alu_a), 32'd0);
    chk({tag, "_b"}, 32'(ifc.alu_b), 32'd0);
    chk({tag, "_fun"}, 32'(ifc.alu_fun), 32'd0);
    chk({tag, "_usel"}, 32'(ifc.unit_sel), 32'd0);
  endtask

  // Compare everything the model knows; the presented command only matters
  // while issue_valid is expected high.
  task automatic checkOutput();
    chk("issue_valid", 32'(ifc.issue_valid), 32'(m_valid));
    chk("fifo_level", 32'(ifc.fifo_level), 32'(mq.size()));
    chk("cmd_ready", 32'(ifc.cmd_ready),
        32'((mq.size() < DEPTH) && !ifc.flush));
    chk("issue_count", 32'(ifc.issue_count), 32'(m_count));
    if (m_valid) begin
      chk("alu_a", 32'(ifc.alu_a), 32'(m_cmd.a));
      chk("alu_b", 32'(ifc.alu_b), 32'(m_cmd.b));
      chk("alu_fun", 32'(ifc.alu_fun), 32'(m_cmd.f));
      chk("unit_sel", 32'(ifc.unit_sel), 32'(m_cmd.f / 4));
    end
  endtask

  // One clock: drive inputs, step the model by the handshake rules at the
  // edge, then compare shortly after the edge.
  task automatic driveCycle(input bit v, input cmd_t c, input bit fl,
                            input bit ar);
    bit   accept;
    bit   xfer;
    ifc.cmd_valid = v;
    ifc.cmd_a     = c.a;
    ifc.cmd_b     = c.b;
    ifc.cmd_fun   = c.f;
    ifc.flush     = fl;
    ifc.alu_ready = ar;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_valid = 1'b0;
    end else begin
      accept = v && (mq.size() < DEPTH);
      xfer   = m_valid && ar;
      if (xfer) begin
        m_count = m_count + 8'd1;
        m_total++;
      end
      if ((!m_valid || xfer) && mq.size() > 0) begin
        m_cmd   = mq.pop_front();
        m_valid = 1'b1;
      end else if (xfer) begin
        m_valid = 1'b0;
      end
      if (accept) mq.push_back(c);
    end
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input bit v, input bit fl, input bit ar);
    cmd_t c;
    c.a = DW'($urandom);
    c.b = DW'($urandom);
    c.f = 4'($urandom);
    driveCycle(v, c, fl, ar);
  endtask

  task automatic doReset();
    rst = 1'b1;
    ifc.cmd_valid = 1'b0;
    ifc.flush     = 1'b0;
    ifc.alu_ready = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
  endtask

  initial begin
    cmd_t c;
    int   guard;
    ifc.cmd_a   = '0;
    ifc.cmd_b   = '0;
    ifc.cmd_fun = '0;
    doReset();
    checkReset("reset");

    // Single command: visible after the second edge, counted after the third.
    c.a = 16'h0005; c.b = 16'h0003; c.f = 4'b0110;
    driveCycle(1'b1, c, 1'b0, 1'b1);
    chk("lat_not_yet", 32'(ifc.issue_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    chk("lat_valid", 32'(ifc.issue_valid), 32'd1);
    chk("lat_fun", 32'(ifc.alu_fun), 32'd6);
    chk("lat_usel", 32'(ifc.unit_sel), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    chk("lat_count", 32'(ifc.issue_count), 32'd1);

    // Fill: five pushes with the ALU stalled, then a refused sixth.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    chk("fill_level", 32'(ifc.fifo_level), 32'd4);
    chk("fill_ready", 32'(ifc.cmd_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    chk("fill_refused", 32'(ifc.fifo_level), 32'd4);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    chk("drain_count", 32'(ifc.issue_count), 32'd6);

    // Sustained streaming.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b1);

    // Stall while loaded: everything holds.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);

    // Build level 3 with a loaded stage, then flush with everything active.
    while (mq.size() < 3) applyStimulus(1'b1, 1'b0, 1'b0);
    chk("pre_flush_valid", 32'(ifc.issue_valid), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    chk("flush_level", 32'(ifc.fifo_level), 32'd0);
    chk("flush_valid", 32'(ifc.issue_valid), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);

    // Counter wrap: 256 issues from reset brings the count back to zero.
    doReset();
    guard = 0;
    while (m_total < 256 && guard < 600) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      guard++;
    end
    chk("wrap_budget", 32'(m_total), 32'd256);
    chk("wrap_count", 32'(ifc.issue_count), 32'd0);

    // Random traffic including occasional flushes.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-stream, asserted between edges.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    ifc.cmd_valid = 1'b0;
    ifc.alu_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkReset("async_rst");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command-issue stage directly upstream of the ALU unit decoder. Accepts ALU commands (operands plus 4-bit function code) over a valid/ready handshake, buffers them in a small FIFO, and presents them one per cycle to the ALU through a registered output stage. It drives the 2-bit unit select the decoder turns into one-hot unit enables, and keeps a wrap-around count of issued commands.

## Interface
- DATA_WIDTH, 16, operand width
- FIFO_DEPTH, 4, command buffer entries; power of two, ≥2
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  asynchronous, active-high reset
- CMD_VALID  input  1  upstream command present
- CMD_READY  output  1  block can accept a command this cycle
- CMD_A  input  DATA_WIDTH  operand A
- CMD_B  input  DATA_WIDTH  operand B
- CMD_FUN  input  4  ALU function code; [3:2] selects unit, [1:0] selects operation
- FLUSH  input  1  synchronous discard of all buffered and pending commands
- ISSUE_VALID  output  1  ALU_A/ALU_B/ALU_FUN/UNIT_SEL hold a command
- ALU_READY  input  1  ALU consumes the presented command this cycle
- ALU_A  output  DATA_WIDTH  issued operand A
- ALU_B  output  DATA_WIDTH  issued operand B
- ALU_FUN  output  4  issued function code
- UNIT_SEL  output  2  equals ALU_FUN[3:2]; feeds the unit decoder
- FIFO_LEVEL  output  log2(FIFO_DEPTH)+1  number of buffered entries (excludes output stage)
- ISSUE_COUNT  output  8  count of completed issue transfers

## Operation
- Accept: CMD_VALID & CMD_READY at an edge writes {CMD_A, CMD_B, CMD_FUN} into the FIFO.
- CMD_READY = ~full & ~FLUSH; full means FIFO_LEVEL == FIFO_DEPTH. Ready does not consider a same-cycle pop: no write when full even if a pop occurs.
- Output-stage FSM, two states:
  - EMPTY: ISSUE_VALID=0. If FIFO non-empty: pop head into output registers → LOADED.
  - LOADED: ISSUE_VALID=1, outputs stable. On ALU_READY: ISSUE_COUNT+1; if FIFO non-empty, pop next entry into output registers, stay LOADED; otherwise → EMPTY. Without ALU_READY: hold all outputs unchanged.
- Transfer = ISSUE_VALID & ALU_READY at an edge. ALU_READY while EMPTY is ignored.
- Simultaneous push and pop: level unchanged, both take effect; pushing into an empty FIFO is not bypassed to the output stage.
- FIFO pointers are log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH; FIFO_LEVEL increments on push-only, decrements on pop-only.
- ISSUE_COUNT wraps 255 → 0; not cleared by FLUSH.
- FLUSH (highest priority): at the edge, FIFO level and pointers → 0, FSM → EMPTY, ISSUE_VALID → 0; no push, no pop, no ISSUE_COUNT increment even if ALU_READY is high that cycle. ALU_A/ALU_B/ALU_FUN/UNIT_SEL keep their last values (don't-care while ISSUE_VALID=0).
- Every CMD_FUN value 0–15 is legal and passed through unmodified.

## Timing
- Reset (RST high, asynchronous): FSM=EMPTY, FIFO_LEVEL=0, pointers=0, ISSUE_VALID=0, ALU_A=0, ALU_B=0, ALU_FUN=0, UNIT_SEL=0, ISSUE_COUNT=0. CMD_READY=1 once RST is low with FLUSH low.
- Reset asserted mid-operation discards all buffered and pending commands immediately, without waiting for a clock edge.
- Latency: command accepted at edge N into an empty FIFO with FSM EMPTY → ISSUE_VALID high after edge N+1.
- Throughput: one issue per cycle sustained while ALU_READY=1 and the FIFO is non-empty.
- CMD_READY and ISSUE_VALID depend only on registered state, plus FLUSH for CMD_READY; no combinational path from ALU_READY to CMD_READY.

## Test plan
- Reset, then one command A=0x0005, B=0x0003, FUN=4'b0110 accepted at edge 1 with ALU_READY=1 → ISSUE_VALID high after edge 2 with ALU_FUN=6, UNIT_SEL=1; ISSUE_COUNT=1 after edge 3.
- ALU_READY=0, push 5 commands (FIFO_DEPTH=4) → one in output stage, FIFO_LEVEL=4, CMD_READY=0; a 6th CMD_VALID is not accepted. Raise ALU_READY → 5 commands issue in order on 5 consecutive edges.
- Continuous push and ALU_READY=1 for 20 cycles → one issue per cycle, FIFO_LEVEL constant at its steady value, command order preserved.
- Hold ALU_READY=0 for 3 cycles while LOADED → ALU_A/ALU_B/ALU_FUN unchanged, ISSUE_COUNT unchanged.
- FLUSH with FIFO_LEVEL=3, ISSUE_VALID=1, ALU_READY=1, CMD_VALID=1 → after the edge FIFO_LEVEL=0, ISSUE_VALID=0, ISSUE_COUNT unchanged, incoming command dropped.
- Issue 256 commands from reset → ISSUE_COUNT returns to 0; assert RST mid-stream → all outputs return to reset values before the next clock edge.
